// File: rtl/dpll_pkg.sv
// Shared types and constants for the DPLL trim controller.
package dpll_pkg;
   localparam int CODE_W   = 5;
   localparam int CODE_MAX = 26;
   localparam int TRIM_W   = 26;

   typedef enum logic [1:0] {
      WAIT0 = 2'd0,
      WAIT1 = 2'd1,
      TRACK = 2'd2
   } state_t;
endpackage

// File: rtl/dpll_trim_encode.sv
// Combinational trim code -> 26-bit thermometer for the DCO.
// Bit order is {secondary[12:0], primary[12:0]}, so filling bits from bit 0
// upward puts every primary bit in before any secondary bit, one per step.
module dpll_trim_encode
   import dpll_pkg::*;
(
   input  logic [CODE_W-1:0] code,
   output logic [TRIM_W-1:0] trim
);

   for (genvar i = 0; i < TRIM_W; i++) begin : g_bit
      assign trim[i] = (CODE_W'(i) < code);
   end

endmodule

// File: rtl/dpll_trim_ctrl.sv
// Frequency-acquisition controller for the trimmed ring-oscillator DCO.
// Counts DCO cycles per osc period and steps a 0..26 trim code toward div.
// Optional lock detector: define DPLL_LOCK_DETECT_EN.
module dpll_trim_ctrl
   import dpll_pkg::*;
#(
   parameter int CNT_W      = 7,
   parameter int HYST       = 1,
   parameter int START_CODE = 13,
   parameter int LOCK_CNT   = 8
) (
   input  logic              clock,
   input  logic              resetb,
   input  logic              enable,
   input  logic              osc,
   input  logic [CNT_W-1:0]  div,
   input  logic              freeze,
   output logic [TRIM_W-1:0] trim,
   output logic              dco_reset,
   output logic [CODE_W-1:0] code,
   output logic              locked
);

   localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [TRIM_W-1:0] TRIM_RST = TRIM_W'((64'd1 << START_CODE) - 64'd1);

   // The ring is stopped while cleared, so the clear must not need a clock.
   logic rst_n;
   assign rst_n     = resetb & enable;
   assign dco_reset = ~rst_n;

   logic [2:0]        osc_q;
   logic              ref_edge;
   logic [CNT_W-1:0]  cnt, meas;
   logic              pend;
   state_t            state_q, state_d;
   logic              up, dn;
   logic [CODE_W-1:0] code_nxt;
   logic [TRIM_W-1:0] trim_d;

   // Two-flop synchronizer plus history flop for rising-edge detect.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) osc_q <= '0;
      else        osc_q <= {osc_q[1:0], osc};
   end
   assign ref_edge = osc_q[1] & ~osc_q[2];

   // DCO-cycle counter per reference window; meas latches the closing count.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= '0;
         meas <= '0;
      end else if (ref_edge) begin
         cnt  <= CNT_W'(1);
         meas <= cnt;
      end else if (cnt != CNT_MAX) begin
         cnt  <= cnt + 1'b1;
      end
   end

   // FSM state register.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) state_q <= WAIT0;
      else        state_q <= state_d;
   end

   // Next state: two edges close out partial windows, then track forever.
   always_comb begin
      state_d = state_q;
      case (state_q)
         WAIT0:   if (ref_edge) state_d = WAIT1;
         WAIT1:   if (ref_edge) state_d = TRACK;
         TRACK:   state_d = TRACK;
         default: state_d = WAIT0;
      endcase
   end

   // Decision is taken the cycle after the edge, from the registered meas.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) pend <= 1'b0;
      else        pend <= ref_edge && (state_q == TRACK);
   end

   // Dead-band compare; two extra bits keep div+HYST from wrapping and
   // let div-HYST go negative (so nothing is ever "too slow" near zero).
   always_comb begin
      logic signed [CNT_W+1:0] m_s, hi_s, lo_s;
      m_s  = $signed({2'b00, meas});
      hi_s = $signed({2'b00, div}) + (CNT_W+2)'(HYST);
      lo_s = $signed({2'b00, div}) - (CNT_W+2)'(HYST);
      up   = (meas == CNT_MAX) || (m_s > hi_s);
      dn   = !up && (m_s < lo_s);
      if (freeze || (div == '0)) begin
         up = 1'b0;
         dn = 1'b0;
      end
   end

   // Saturating code step on a pending decision.
   always_comb begin
      code_nxt = code;
      if (pend) begin
         if (up && (code != CODE_W'(CODE_MAX))) code_nxt = code + 1'b1;
         else if (dn && (code != '0))           code_nxt = code - 1'b1;
      end
   end

   dpll_trim_encode u_enc (
      .code (code_nxt),
      .trim (trim_d)
   );

   // Code and trim register together so the DCO sees one clean step.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         code <= CODE_W'(START_CODE);
         trim <= TRIM_RST;
      end else begin
         code <= code_nxt;
         trim <= trim_d;
      end
   end

`ifdef DPLL_LOCK_DETECT_EN
   localparam int LCW = $clog2(LOCK_CNT + 1);
   logic [LCW-1:0] lcnt;

   // Count consecutive hold decisions; any up/down decision restarts.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) lcnt <= '0;
      else if (pend) begin
         if (up || dn)                     lcnt <= '0;
         else if (lcnt != LCW'(LOCK_CNT))  lcnt <= lcnt + 1'b1;
      end
   end
   assign locked = (lcnt == LCW'(LOCK_CNT));
`else
   assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_dpll_trim_ctrl.sv
// Scoreboard bench: the bench owns osc timing in DCO cycles, so the measured
// count of each window is known exactly; a reference model pushes the
// expected code/trim/locked per osc edge and a check pops it after latency.
module tb_dpll_trim_ctrl;
   logic        clock = 1'b0;
   logic        resetb, enable, osc, freeze;
   logic [6:0]  div;
   logic [25:0] trim;
   logic        dco_reset, locked;
   logic [4:0]  code;

   dpll_trim_ctrl dut (
      .clock     (clock),
      .resetb    (resetb),
      .enable    (enable),
      .osc       (osc),
      .div       (div),
      .freeze    (freeze),
      .trim      (trim),
      .dco_reset (dco_reset),
      .code      (code),
      .locked    (locked)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [4:0]  code;
      logic [25:0] trim;
      logic        locked;
   } exp_t;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // model state
   int m_edges, m_code, m_lc, prev_len;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // {secondary, primary}: primary fills to 13 bits, then secondary.
   function automatic logic [25:0] exp_trim(input int k);
      logic [12:0] p, s;
      p = (k >= 13) ? 13'h1FFF : 13'((1 << k) - 1);
      s = (k > 13)  ? 13'((1 << (k - 13)) - 1) : 13'h0;
      return {s, p};
   endfunction

   function automatic logic exp_locked();
`ifdef DPLL_LOCK_DETECT_EN
      return (m_lc == 8);
`else
      return 1'b0;
`endif
   endfunction

   task automatic model_reset();
      m_edges  = 0;
      m_code   = 13;
      m_lc     = 0;
      prev_len = -1;
   endtask

   // One reference edge closing a window of meas DCO cycles.
   task automatic model_edge(input int meas);
      exp_t e;
      bit   hold, up, dn;
      m_edges++;
      if (m_edges >= 3) begin
         hold = freeze || (div == 0);
         up   = !hold && (meas >= 127 || meas > int'(div) + 1);
         dn   = !hold && !up && (meas < int'(div) - 1);
         if (up && m_code < 26) m_code++;
         else if (dn && m_code > 0) m_code--;
         if (up || dn) m_lc = 0;
         else if (m_lc < 8) m_lc++;
      end
      e.code   = 5'(m_code);
      e.trim   = exp_trim(m_code);
      e.locked = exp_locked();
      q.push_back(e);
   endtask

   // One osc period: high for hi DCO cycles, low for lo; check 7 cycles in.
   task automatic osc_cycle(input int hi, input int lo);
      exp_t e;
      int   meas;
      @(negedge clock);
      osc  = 1'b1;
      meas = (prev_len > 127) ? 127 : prev_len;
      model_edge(meas);
      for (int i = 1; i < hi + lo; i++) begin
         @(negedge clock);
         if (i == hi) osc = 1'b0;
         if (i == 7) begin
            if (q.size() == 0) chk("sb_underflow", 32'd0, 32'd1);
            else begin
               e = q.pop_front();
               chk("code",   32'(code),   32'(e.code));
               chk("trim",   32'(trim),   32'(e.trim));
               chk("locked", 32'(locked), 32'(e.locked));
            end
         end
      end
      prev_len = hi + lo;
   endtask

   task automatic cycles(input int n, input int hi, input int lo);
      for (int k = 0; k < n; k++) osc_cycle(hi, lo);
   endtask

   initial begin
      resetb = 1'b0; enable = 1'b1; osc = 1'b0; freeze = 1'b0; div = 7'd20;
      model_reset();
      #12;
      chk("rst_dco_reset", 32'(dco_reset), 32'd1);
      chk("rst_code",      32'(code),      32'd13);
      chk("rst_trim",      32'(trim),      32'h0001FFF);
      chk("rst_locked",    32'(locked),    32'd0);
      @(negedge clock);
      resetb = 1'b1;
      #1 chk("rel_dco_reset", 32'(dco_reset), 32'd0);

      // fast DCO: two ignored edges, then one step up per period
      cycles(4, 12, 12);
      // in band: lock builds over consecutive holds
      cycles(10, 10, 10);
      // out of band by 3: step up, lock lost
      cycles(2, 12, 11);
      // dead-band edges: 21 hold, 22 up, 19 hold, 18 down, 20 hold
      osc_cycle(11, 10); osc_cycle(11, 11); osc_cycle(10, 9);
      osc_cycle(9, 9);   cycles(2, 10, 10);
      // drive to top saturation and past it
      cycles(14, 20, 20);
      // drive to bottom saturation and past it
      cycles(30, 5, 5);
      // freeze holds with meas = div+5, release steps again
      freeze = 1'b1;
      cycles(3, 13, 12);
      freeze = 1'b0;
      cycles(2, 13, 12);

      // enable dropped mid-track: immediate clear, then two edges ignored
      @(negedge clock);
      enable = 1'b0;
      #1;
      chk("clr_dco_reset", 32'(dco_reset), 32'd1);
      chk("clr_code",      32'(code),      32'd13);
      chk("clr_trim",      32'(trim),      32'h0001FFF);
      chk("clr_locked",    32'(locked),    32'd0);
      repeat (3) @(negedge clock);
      enable = 1'b1;
      model_reset();
      #1 chk("reen_dco_reset", 32'(dco_reset), 32'd0);
      cycles(3, 12, 12);

      // osc stalled: count saturates at 127, read as too fast
      osc_cycle(5, 200);
      osc_cycle(12, 12);
      cycles(1, 12, 12);

      chk("sb_drained", 32'(q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
